// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle CPU control sequencer with memory handshake and timeout
module cpu_sequencer #(
    parameter int TIMEOUT = 15,
    parameter int CW      = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run,
    input  logic [3:0]    opcode,
    input  logic          zero_flag,
    input  logic          mem_ack,
    output logic          mem_req,
    output logic          mem_we,
    output logic          addr_sel,
    output logic          ir_load,
    output logic          pc_inc,
    output logic          pc_load,
    output logic          reg_we,
    output logic [1:0]    alu_op,
    output logic          instr_done,
    output logic          halted,
    output logic          fault,
    output logic          illegal,
    output logic [CW-1:0] cycle_cnt
);

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, FAULT
    } state_t;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_JMP   = 4'h5;
    localparam logic [3:0] OP_JZ    = 4'h6;
    localparam logic [3:0] OP_HALT  = 4'hf;
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t        state, state_n;
    logic [3:0]    op_q;
    logic [7:0]    wait_cnt;
    logic          illegal_q;
    logic [CW-1:0] cnt_q;
    logic          boundary;
    logic          illegal_op;
    logic          active;

    assign illegal_op = !(opcode inside {OP_NOP, OP_LOAD, OP_STORE, OP_ADD,
                                         OP_SUB, OP_JMP, OP_JZ, OP_HALT});
    assign active     = state inside {FETCH, DECODE, EXEC, MEM, WB};

    always_comb begin
        state_n    = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_sel   = 1'b0;
        ir_load    = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        reg_we     = 1'b0;
        alu_op     = 2'b00;
        boundary   = 1'b0;
        case (state)
            IDLE: if (run) state_n = FETCH;
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_load = 1'b1;
                    pc_inc  = 1'b1;
                    state_n = DECODE;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_n = FAULT;
                end
            end
            DECODE: begin
                // opcode is the freshly loaded IR; illegal codes fall through as NOP
                case (opcode)
                    OP_LOAD, OP_STORE:             state_n = MEM;
                    OP_ADD, OP_SUB, OP_JMP, OP_JZ: state_n = EXEC;
                    OP_HALT:                       state_n = HALT;
                    default:                       boundary = 1'b1;
                endcase
            end
            EXEC: begin
                case (op_q)
                    OP_ADD: begin alu_op = 2'b01; state_n = WB; end
                    OP_SUB: begin alu_op = 2'b10; state_n = WB; end
                    OP_JMP: begin pc_load = 1'b1; boundary = 1'b1; end
                    OP_JZ:  begin pc_load = zero_flag; boundary = 1'b1; end
                    default: boundary = 1'b1;
                endcase
            end
            MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = (op_q == OP_STORE);
                if (mem_ack) begin
                    if (op_q == OP_LOAD) state_n = WB;
                    else                 boundary = 1'b1;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_n = FAULT;
                end
            end
            WB: begin
                reg_we   = 1'b1;
                boundary = 1'b1;
            end
            HALT:    state_n = HALT;
            FAULT:   state_n = FAULT;
            default: state_n = IDLE;
        endcase
        instr_done = boundary;
        if (boundary) state_n = run ? FETCH : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_q      <= OP_NOP;
            wait_cnt  <= 8'd0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state <= state_n;
            if (state == DECODE) op_q <= opcode;
            // counts unanswered request cycles; any ack or other state restarts it
            if ((state == FETCH || state == MEM) && !mem_ack) wait_cnt <= wait_cnt + 8'd1;
            else                                              wait_cnt <= 8'd0;
            if (state == DECODE && illegal_op) illegal_q <= 1'b1;
            if (active && cnt_q != {CW{1'b1}}) cnt_q <= cnt_q + CW'(1);
        end
    end

    assign halted    = (state == HALT);
    assign fault     = (state == FAULT);
    assign illegal   = illegal_q;
    assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - directed self-checking bench for cpu_sequencer
module tb_cpu_sequencer;

    localparam int TO   = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    // {mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load, reg_we, alu_op[1:0], instr_done, halted, fault, illegal}
    localparam logic [12:0] MREQ = 13'h1000;
    localparam logic [12:0] MWE  = 13'h0800;
    localparam logic [12:0] ASEL = 13'h0400;
    localparam logic [12:0] IRL  = 13'h0200;
    localparam logic [12:0] PCI  = 13'h0100;
    localparam logic [12:0] PCL  = 13'h0080;
    localparam logic [12:0] RWE  = 13'h0040;
    localparam logic [12:0] AADD = 13'h0010;
    localparam logic [12:0] ASUB = 13'h0020;
    localparam logic [12:0] DONE = 13'h0008;
    localparam logic [12:0] HLT  = 13'h0004;
    localparam logic [12:0] FLT  = 13'h0002;
    localparam logic [12:0] ILL  = 13'h0001;

    logic          clk = 1'b0;
    logic          rst_n, run, zero_flag, mem_ack;
    logic [3:0]    opcode;
    logic          mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load, reg_we;
    logic [1:0]    alu_op;
    logic          instr_done, halted, fault, illegal;
    logic [CW-1:0] cycle_cnt;
    logic [12:0]   outv;

    int checks = 0;
    int errors = 0;
    int m_cnt  = 0;
    bit m_ill  = 0;
    bit term;

    cpu_sequencer #(.TIMEOUT(TO), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .zero_flag(zero_flag),
        .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
        .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load), .reg_we(reg_we),
        .alu_op(alu_op), .instr_done(instr_done), .halted(halted), .fault(fault),
        .illegal(illegal), .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    assign outv = {mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load, reg_we,
                   alu_op, instr_done, halted, fault, illegal};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, compare outputs against the model at the falling edge.
    task automatic tick(input logic r, input logic a, input logic z,
                        input logic [12:0] e, input bit act, input string tag);
        run = r; mem_ack = a; zero_flag = z;
        @(negedge clk);
        chk({tag, " outputs"}, 32'(outv), 32'(e | (m_ill ? ILL : 13'h0)));
        chk({tag, " cycle_cnt"}, 32'(cycle_cnt), 32'(m_cnt));
        @(posedge clk);
        #1;
        if (act && m_cnt < CMAX) m_cnt++;
    endtask

    task automatic stuck(input logic [12:0] e, input string tag);
        for (int i = 0; i < 3; i++) tick(i % 2 == 1, i % 2 == 1, 1'b0, e, 1'b0, tag);
    endtask

    // Expected trace of one instruction built from its phases; entered with the DUT in FETCH.
    task automatic run_instr(input logic [3:0] op, input int fd, input int md,
                             input logic z, input logic ra, output bit terminal);
        bit legal;
        logic [12:0] mv;
        terminal = 0;
        opcode = op;
        for (int i = 0; i < fd && i < TO; i++) tick(1'b1, 1'b0, z, MREQ, 1'b1, "fetch_wait");
        if (fd >= TO) begin stuck(FLT, "fault"); terminal = 1; return; end
        tick(1'b1, 1'b1, z, MREQ | IRL | PCI, 1'b1, "fetch");
        legal = op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hf};
        if (op == 4'hf) begin
            tick(1'b1, 1'b1, z, 13'h0, 1'b1, "decode");
            stuck(HLT, "halt");
            terminal = 1;
            return;
        end
        if (!legal || op == 4'h0) begin
            tick(ra, 1'b1, z, DONE, 1'b1, "decode_nop");
            if (!legal) m_ill = 1;
            return;
        end
        tick(1'b1, 1'b1, z, 13'h0, 1'b1, "decode");
        case (op)
            4'h3, 4'h4: begin
                tick(1'b1, 1'b0, z, (op == 4'h3) ? AADD : ASUB, 1'b1, "exec");
                tick(ra, 1'b0, z, RWE | DONE, 1'b1, "wb");
            end
            4'h5: tick(ra, 1'b0, z, PCL | DONE, 1'b1, "jmp");
            4'h6: tick(ra, 1'b0, z, (z ? PCL : 13'h0) | DONE, 1'b1, "jz");
            default: begin
                mv = MREQ | ASEL | ((op == 4'h2) ? MWE : 13'h0);
                for (int i = 0; i < md && i < TO; i++) tick(1'b1, 1'b0, z, mv, 1'b1, "mem_wait");
                if (md >= TO) begin stuck(FLT, "fault"); terminal = 1; return; end
                if (op == 4'h2) begin
                    tick(ra, 1'b1, z, mv | DONE, 1'b1, "mem_store");
                end else begin
                    tick(1'b1, 1'b1, z, mv, 1'b1, "mem_load");
                    tick(ra, 1'b0, z, RWE | DONE, 1'b1, "wb");
                end
            end
        endcase
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        m_cnt = 0;
        m_ill = 0;
        tick(1'b1, 1'b1, 1'b0, 13'h0, 1'b0, "reset");
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; mem_ack = 1'b0; zero_flag = 1'b0; opcode = 4'h0;
        @(posedge clk);
        #1;
        tick(1'b1, 1'b1, 1'b0, 13'h0, 1'b0, "reset");
        tick(1'b1, 1'b1, 1'b0, 13'h0, 1'b0, "reset");
        rst_n = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 13'h0, 1'b0, "idle");
        tick(1'b0, 1'b0, 1'b0, 13'h0, 1'b0, "idle");

        tick(1'b1, 1'b0, 1'b0, 13'h0, 1'b0, "idle_go");
        run_instr(4'h3, 0, 0, 1'b0, 1'b1, term);
        chk("add cycle_cnt literal", 32'(cycle_cnt), 32'd4);
        run_instr(4'h2, 0, 3, 1'b0, 1'b1, term);
        run_instr(4'h6, 0, 0, 1'b0, 1'b1, term);
        run_instr(4'h6, 0, 0, 1'b1, 1'b1, term);
        chk("saturated cycle_cnt literal", 32'(cycle_cnt), 32'd15);
        run_instr(4'h5, 0, 0, 1'b0, 1'b1, term);
        run_instr(4'h0, 3, 0, 1'b0, 1'b1, term);
        run_instr(4'h4, 0, 0, 1'b0, 1'b1, term);
        run_instr(4'h1, 2, 1, 1'b0, 1'b1, term);
        run_instr(4'h9, 0, 0, 1'b0, 1'b0, term);
        chk("illegal literal", 32'(illegal), 32'd1);
        tick(1'b0, 1'b0, 1'b0, 13'h0, 1'b0, "idle");

        // reset while a LOAD is waiting in MEM
        tick(1'b1, 1'b0, 1'b0, 13'h0, 1'b0, "idle_go");
        opcode = 4'h1;
        tick(1'b1, 1'b1, 1'b0, MREQ | IRL | PCI, 1'b1, "fetch");
        tick(1'b1, 1'b0, 1'b0, 13'h0, 1'b1, "decode");
        tick(1'b1, 1'b0, 1'b0, MREQ | ASEL, 1'b1, "mem_wait");
        tick(1'b1, 1'b0, 1'b0, MREQ | ASEL, 1'b1, "mem_wait");
        rst_n = 1'b0;
        #1;
        chk("async reset outputs literal", 32'(outv), 32'd0);
        chk("async reset cycle_cnt literal", 32'(cycle_cnt), 32'd0);
        m_cnt = 0;
        m_ill = 0;
        tick(1'b1, 1'b0, 1'b0, 13'h0, 1'b0, "reset");
        rst_n = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 13'h0, 1'b0, "idle");

        tick(1'b1, 1'b0, 1'b0, 13'h0, 1'b0, "idle_go");
        run_instr(4'hf, 0, 0, 1'b0, 1'b1, term);
        chk("halted literal", 32'(halted), 32'd1);
        chk("halt cycle_cnt literal", 32'(cycle_cnt), 32'd2);

        do_reset();
        tick(1'b1, 1'b0, 1'b0, 13'h0, 1'b0, "idle_go");
        run_instr(4'h0, TO, 0, 1'b0, 1'b1, term);
        chk("fetch fault literal", 32'(fault), 32'd1);
        chk("fetch fault cycle_cnt literal", 32'(cycle_cnt), 32'd4);

        do_reset();
        tick(1'b1, 1'b0, 1'b0, 13'h0, 1'b0, "idle_go");
        run_instr(4'h2, 0, TO, 1'b0, 1'b1, term);
        chk("mem fault literal", 32'(fault), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter: TIMEOUT, 15, max wait cycles for mem_ack per memory access (2..255).
REQ-002 Parameter: CW, 16, width of cycle_cnt.
REQ-003 Port: clk  in  1  single clock, all state on rising edge.
REQ-004 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-005 Port: run  in  1  enable; sampled in IDLE and at instruction boundaries.
REQ-006 Port: opcode  in  4  IR[7:4]; 0 NOP, 1 LOAD, 2 STORE, 3 ADD, 4 SUB, 5 JMP, 6 JZ, F HALT, others illegal.
REQ-007 Port: zero_flag  in  1  ALU zero flag.
REQ-008 Port: mem_ack  in  1  memory completion; ignored while mem_req=0.
REQ-009 Port: mem_req  out  1  memory access request.
REQ-010 Port: mem_we  out  1  write qualifier, valid with mem_req.
REQ-011 Port: addr_sel  out  1  0 = PC address, 1 = operand address.
REQ-012 Port: ir_load, pc_inc, pc_load, reg_we  out  1 each  single-cycle datapath strobes.
REQ-013 Port: alu_op  out  2  00 pass, 01 add, 10 sub.
REQ-014 Port: instr_done  out  1  one-cycle retire pulse.
REQ-015 Port: halted, fault, illegal  out  1 each  sticky status.
REQ-016 Port: cycle_cnt  out  CW  active-cycle counter.

Function
REQ-017 States SHALL be IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, FAULT; all outputs Moore-decoded from state plus latched opcode, except strobes gated by mem_ack/zero_flag as stated.
REQ-018 IDLE: run=1 -> FETCH; else stay.
REQ-019 FETCH: mem_req=1, addr_sel=0, mem_we=0; on mem_ack: ir_load=1, pc_inc=1 same cycle -> DECODE.
REQ-020 DECODE: latch opcode into internal register; NOP/illegal -> boundary; LOAD/STORE -> MEM; ADD/SUB/JMP/JZ -> EXEC; HALT -> HALT.
REQ-021 Illegal opcode SHALL set illegal (sticky) and execute as NOP.
REQ-022 EXEC: ADD alu_op=01, SUB alu_op=10, -> WB; JMP pc_load=1; JZ pc_load=zero_flag; jumps -> boundary.
REQ-023 MEM: mem_req=1, addr_sel=1, mem_we=1 iff STORE; on mem_ack LOAD -> WB (alu_op=00), STORE -> boundary.
REQ-024 WB: reg_we=1 for one cycle -> boundary.
REQ-025 Boundary: instr_done=1 for that cycle; next state FETCH if run=1, else IDLE.
REQ-026 mem_req, mem_we, addr_sel SHALL remain stable until the cycle mem_ack is sampled high.
REQ-027 Wait counter clears on entry to FETCH/MEM, increments each cycle without ack; if TIMEOUT cycles elapse without ack -> FAULT; ack in the TIMEOUT-th cycle wins.
REQ-028 HALT: halted=1, all strobes 0, exit only via reset; FAULT: fault=1, same.
REQ-029 cycle_cnt increments each cycle in FETCH..WB, saturates at 2^CW-1, holds in IDLE/HALT/FAULT.
REQ-030 Zero-wait latencies (ack in first request cycle): NOP 2, JMP/JZ/STORE 3, ADD/SUB/LOAD 4 cycles FETCH-entry to instr_done.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE, all outputs 0, cycle_cnt=0, wait counter 0, sticky flags cleared, regardless of state or pending mem_req.
REQ-032 After rst_n release, first transition occurs on first rising edge with run=1.

Verification
REQ-033 run=1, zero-wait memory, opcode=3 -> mem_req 1 cycle, ir_load+pc_inc, DECODE, alu_op=01, reg_we, instr_done on cycle 4, cycle_cnt=4.
REQ-034 opcode=2, ack delayed 3 cycles in MEM -> mem_we=1 held stable 4 cycles, no reg_we, instr_done after ack.
REQ-035 opcode=6 with zero_flag=0 then 1 -> pc_load=0 then 1, pc_inc=1 in both FETCH cycles.
REQ-036 TIMEOUT=4, no ack in FETCH -> FAULT after 4 wait cycles, fault=1; ack on 4th cycle variant -> DECODE, no fault.
REQ-037 opcode=F -> halted=1, cycle_cnt frozen, run toggling ignored; opcode=9 -> illegal=1, continues as NOP.
REQ-038 rst_n=0 asserted mid-MEM with mem_req=1 -> mem_req=0 immediately (asynchronous), IDLE, all flags cleared.
